// File: rtl/decode_pkg.sv
// decode_pkg: shared opcodes, format codes and the decoded-record type for the decode stage
// Contents: RV32/RV64 base opcode constants, fmt_e format codes (R=0 .. NONE=6),
// decoded_t record carrying every out_* payload field. pc/imm are held at the widest
// supported XLEN and narrowed by the consumer.
package decode_pkg;
  localparam int XLEN_MAX = 64;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    fmt_e                fmt;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                we;
    logic                re1;
    logic                re2;
    logic                illegal;
  } decoded_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage
// master: producer/consumer environment (drives flush, in_*, out_ready)
// slave:  decode_stage (drives in_ready, out_valid and the decoded payload)
interface decode_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_we;
  logic            out_re1;
  logic            out_re2;
  logic            out_illegal;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_fmt, out_opcode, out_funct3,
           out_funct7, out_rd, out_rs1, out_rs2, out_we, out_re1, out_re2, out_illegal
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_fmt, out_opcode, out_funct3,
           out_funct7, out_rd, out_rs1, out_rs2, out_we, out_re1, out_re2, out_illegal
  );
endinterface

// File: rtl/decode_comb.sv
// decode_comb: combinational RISC-V instruction word -> decoded_t record
// Ports: instr (32b instruction), pc (XLEN), dec (decoded record, pc zero-extended, imm sign-extended to 64b)
// Optional macro DECODE_ILLEGAL_CHECK_EN adds per-opcode funct3/funct7 legality checks;
// without it only the opcode and instr[1:0] are checked.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit RD_X0_SUPPRESS = 1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        known;
  logic        bad;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit RV64 = (XLEN == 64);
  logic sh_bad;
  // RV64 shifts take a 6-bit shamt, so only instr[31:26] qualifies the shift kind
  assign sh_bad = RV64 ?
      (f3 == 3'b001 && instr[31:26] != 6'b0) ||
      (f3 == 3'b101 && instr[31:26] != 6'b0 && instr[31:26] != 6'b010000) :
      (f3 == 3'b001 && f7 != 7'b0) ||
      (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
  assign bad = (op == OP_JALR && f3 != 3'b000) ||
               (op == OP_BRANCH && f3[2:1] == 2'b01) ||
               (op == OP_LOAD && (f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110)))) ||
               (op == OP_STORE && f3 > (RV64 ? 3'd3 : 3'd2)) ||
               (op == OP_IMM && sh_bad) ||
               (op == OP_OP && ((f7 != 7'b0 && f7 != 7'b0100000) ||
                                (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)));
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    dec        = '0;
    known      = 1'b1;
    dec.pc     = 64'(pc);
    dec.opcode = op;
    dec.funct3 = f3;
    dec.funct7 = f7;
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    case (op)
      OP_LUI, OP_AUIPC:        begin dec.fmt = FMT_U; dec.imm = imm_u; dec.we = 1'b1; end
      OP_JAL:                  begin dec.fmt = FMT_J; dec.imm = imm_j; dec.we = 1'b1; end
      OP_JALR, OP_LOAD, OP_IMM: begin dec.fmt = FMT_I; dec.imm = imm_i; dec.we = 1'b1; dec.re1 = 1'b1; end
      OP_BRANCH:               begin dec.fmt = FMT_B; dec.imm = imm_b; dec.re1 = 1'b1; dec.re2 = 1'b1; end
      OP_STORE:                begin dec.fmt = FMT_S; dec.imm = imm_s; dec.re1 = 1'b1; dec.re2 = 1'b1; end
      OP_OP:                   begin dec.fmt = FMT_R; dec.we = 1'b1; dec.re1 = 1'b1; dec.re2 = 1'b1; end
      OP_FENCE, OP_SYSTEM:     dec.fmt = FMT_NONE;
      default:                 begin dec.fmt = FMT_NONE; known = 1'b0; end
    endcase
    dec.illegal = !known || instr[1:0] != 2'b11 || bad;
    if (dec.illegal) begin
      dec.fmt = FMT_NONE;
      dec.imm = '0;
      dec.we  = 1'b0;
      dec.re1 = 1'b0;
      dec.re2 = 1'b0;
    end
    if (RD_X0_SUPPRESS && dec.rd == 5'd0) dec.we = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V decode stage with two-entry skid buffer and flush
// Ports: clk, rst (sync, active-high), bus (decode_stage_if.slave: flush, in_* handshake,
// out_* handshake and decoded payload). Optional macro DECODE_ILLEGAL_CHECK_EN enables
// full field legality checking inside decode_comb.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit RD_X0_SUPPRESS = 1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;
  state_e   state;
  decoded_t dec, m, s;
  logic     in_ready_q;
  logic     acc, drn;
  decode_comb #(.XLEN(XLEN), .RD_X0_SUPPRESS(RD_X0_SUPPRESS)) u_comb (
    .instr(bus.in_instr),
    .pc   (bus.in_pc),
    .dec  (dec)
  );
  // flush refuses the input beat even though in_ready may still read 1
  assign acc = bus.in_valid && in_ready_q && !bus.flush;
  assign drn = state != EMPTY && bus.out_ready;
  // m is the presented entry, s the skid entry that only fills while m is stalled
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      m          <= '0;
      s          <= '0;
    end else
      case (state)
        EMPTY: if (acc) begin m <= dec; state <= BUSY; end
        BUSY:
          if (acc && !drn) begin s <= dec; state <= FULL; in_ready_q <= 1'b0; end
          else if (acc) m <= dec;
          else if (drn) state <= EMPTY;
        FULL: if (drn) begin m <= s; state <= BUSY; in_ready_q <= 1'b1; end
        default: state <= EMPTY;
      endcase
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = state != EMPTY;
  assign bus.out_pc      = XLEN'(m.pc);
  assign bus.out_imm     = XLEN'(m.imm);
  assign bus.out_fmt     = m.fmt;
  assign bus.out_opcode  = m.opcode;
  assign bus.out_funct3  = m.funct3;
  assign bus.out_funct7  = m.funct7;
  assign bus.out_rd      = m.rd;
  assign bus.out_rs1     = m.rs1;
  assign bus.out_rs2     = m.rs2;
  assign bus.out_we      = m.we;
  assign bus.out_re1     = m.re1;
  assign bus.out_re2     = m.re2;
  assign bus.out_illegal = m.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage plus an XLEN=64 decode_comb instance
module tb_decode_stage;
  import decode_pkg::*;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [3:0]  fl;
  } vec_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [3:0]  fl;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] c_instr = 32'h0;
  decoded_t    c_dec;
  vec_t        vecs[12];
  exp_t        sbq[$];
  int          nchk = 0;
  int          npass = 0;
  int          cyc = 0;
  int          t0;
  logic [31:0] pc_n = 32'h1000;
  logic [31:0] pa;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage #(.XLEN(32), .RD_X0_SUPPRESS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  decode_comb #(.XLEN(64), .RD_X0_SUPPRESS(0)) u_c64 (.instr(c_instr), .pc(64'h0), .dec(c_dec));
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic cycle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(vec_t v);
    logic acc;
    int   n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = v.instr;
    bus.in_pc    = pc_n;
    do begin
      @(negedge clk);
      acc = bus.in_ready && !bus.flush;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (acc) begin
      sbq.push_back('{pc_n, v.imm, v.fmt, v.rd, v.fl});
      pc_n += 4;
    end else check("accept_timeout", 64'(bus.in_ready), 1);
  endtask
  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sbq.size(), 0);
  endtask
  always @(negedge clk)
    if (!rst && !bus.flush && bus.out_valid && bus.out_ready) begin
      exp_t e;
      if (sbq.size() == 0) check("unexpected_beat", 64'(bus.out_valid), 0);
      else begin
        e = sbq.pop_front();
        check("pc", bus.out_pc, e.pc);
        check("imm", bus.out_imm, e.imm);
        check("fmt", bus.out_fmt, e.fmt);
        check("rd", bus.out_rd, e.rd);
        check("we", bus.out_we, e.fl[3]);
        check("re1", bus.out_re1, e.fl[2]);
        check("re2", bus.out_re2, e.fl[1]);
        check("illegal", bus.out_illegal, e.fl[0]);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 5'd1,  4'b1100};
    vecs[1]  = '{32'h123452B7, 32'h12345000, 3'd4, 5'd5,  4'b1000};
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 5'd29, 4'b0110};
    vecs[3]  = '{32'h0000006F, 32'h00000000, 3'd5, 5'd0,  4'b0000};
    vecs[4]  = '{32'h00000000, 32'h00000000, 3'd6, 5'd0,  4'b0001};
`ifdef DECODE_ILLEGAL_CHECK_EN
    vecs[5]  = '{32'h40001033, 32'h00000000, 3'd6, 5'd0,  4'b0001};
`else
    vecs[5]  = '{32'h40001033, 32'h00000000, 3'd0, 5'd0,  4'b0110};
`endif
    vecs[6]  = '{32'h0020A423, 32'h00000008, 3'd2, 5'd8,  4'b0110};
    vecs[7]  = '{32'h002081B3, 32'h00000000, 3'd0, 5'd3,  4'b1110};
    vecs[8]  = '{32'h008000EF, 32'h00000008, 3'd5, 5'd1,  4'b1000};
    vecs[9]  = '{32'hFFC12203, 32'hFFFFFFFC, 3'd1, 5'd4,  4'b1100};
    vecs[10] = '{32'h00000073, 32'h00000000, 3'd6, 5'd0,  4'b0000};
    vecs[11] = '{32'hFFF00090, 32'h00000000, 3'd6, 5'd1,  4'b0001};
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;
    cycle(2);
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_imm", bus.out_imm, 0);
    check("rst_pc", bus.out_pc, 0);
    check("rst_fmt", bus.out_fmt, 0);
    check("rst_rd", bus.out_rd, 0);
    check("rst_we", bus.out_we, 0);
    check("rst_illegal", bus.out_illegal, 0);
    bus.out_ready = 1'b1;
    t0 = cyc;
    foreach (vecs[i]) send(vecs[i]);
    check("throughput_cycles", cyc - t0, 12);
    bus.in_valid = 1'b0;
    wait_drain();
    bus.out_ready = 1'b0;
    pa = pc_n;
    send(vecs[0]);
    check("bp_ready_busy", bus.in_ready, 1);
    send(vecs[1]);
    check("bp_ready_full", bus.in_ready, 0);
    check("bp_valid_full", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.in_instr = vecs[2].instr;
    bus.in_pc    = pc_n;
    cycle(2);
    check("bp_still_full", bus.in_ready, 0);
    check("bp_hold_pc", bus.out_pc, pa);
    check("bp_hold_imm", bus.out_imm, vecs[0].imm);
    bus.out_ready = 1'b1;
    t0 = cyc;
    send(vecs[2]);
    check("bp_third_accept_cycles", cyc - t0, 2);
    bus.in_valid = 1'b0;
    wait_drain();
    bus.out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    check("fl_pre_full", bus.in_ready, 0);
    bus.in_instr = vecs[5].instr;
    bus.in_pc    = pc_n;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    cycle(1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    sbq.delete();
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    cycle(3);
    check("fl_no_beat", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    send(vecs[6]);
    send(vecs[7]);
    check("rs_pre_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    sbq.delete();
    check("rs_out_valid", bus.out_valid, 0);
    check("rs_in_ready", bus.in_ready, 1);
    check("rs_imm", bus.out_imm, 0);
    check("rs_pc", bus.out_pc, 0);
    check("rs_fmt", bus.out_fmt, 0);
    check("rs_rd", bus.out_rd, 0);
    check("rs_rs1", bus.out_rs1, 0);
    check("rs_opcode", bus.out_opcode, 0);
    check("rs_we", bus.out_we, 0);
    check("rs_re2", bus.out_re2, 0);
    bus.out_ready = 1'b1;
    send(vecs[8]);
    bus.in_valid = 1'b0;
    wait_drain();
    c_instr = 32'hFE000EE3;
    #1;
    check("x64_b_imm", c_dec.imm, 64'hFFFFFFFFFFFFFFFC);
    check("x64_b_fmt", c_dec.fmt, 3);
    c_instr = 32'h0000006F;
    #1;
    check("nosup_jal_we", c_dec.we, 1);
    check("nosup_jal_fmt", c_dec.fmt, 5);
    c_instr = 32'h40001033;
    #1;
`ifdef DECODE_ILLEGAL_CHECK_EN
    check("x64_op_illegal", c_dec.illegal, 1);
    check("x64_op_fmt", c_dec.fmt, 6);
`else
    check("x64_op_illegal", c_dec.illegal, 0);
    check("x64_op_fmt", c_dec.fmt, 0);
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
